register_file: RTL and testbench

Parametrised multi-port register file that succeeds the single enabled `register` block as the processor's architectural register storage. It holds `NUM_REGS` words of `DATA_WIDTH` bits and provides `NUM_RD_PORTS` combinational read ports and one synchronous write port. Register 0 is hardwired to zero. It sits between the decode stage, which drives read addresses, and the writeback stage, which drives the write port.

---
 rtl/register_file.sv | 61 ++++++
 tb/tb_register_file.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Multi-port architectural register file: NUM_RD_PORTS combinational reads, one synchronous write, r0 hardwired to zero.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGS     = 32,
  parameter int NUM_RD_PORTS = 2,
  localparam int ADDR_W      = $clog2(NUM_REGS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_wr_enable,
  input  logic [ADDR_W-1:0]                i_wr_addr,
  input  logic [DATA_WIDTH-1:0]            i_wr_data,
  input  logic [NUM_RD_PORTS*ADDR_W-1:0]   i_rd_addr,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] view_s [NUM_REGS];

  assign view_s[0] = {DATA_WIDTH{1'b0}};

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_entry
    logic [DATA_WIDTH-1:0] entry_r;
    logic                  hit_s;

    assign hit_s     = i_wr_enable && (i_wr_addr == ADDR_W'(g));
    assign view_s[g] = entry_r;

    // Storage entry: reset has priority over a same-cycle write.
    always_ff @(posedge clk) begin
      if (rst) begin
        entry_r <= {DATA_WIDTH{1'b0}};
      end else if (hit_s) begin
        entry_r <= i_wr_data;
      end else begin
        entry_r <= entry_r;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
    logic [ADDR_W-1:0]     addr_s;
    logic [DATA_WIDTH-1:0] data_s;

    assign addr_s = i_rd_addr[k*ADDR_W +: ADDR_W];
    assign o_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = data_s;

    // Read mux; view_s[0] is constant zero so r0 needs no special case here.
    always_comb begin
      data_s = view_s[addr_s];
`ifdef REGFILE_BYPASS_EN
      if (i_wr_enable && !rst && (addr_s != {ADDR_W{1'b0}}) && (addr_s == i_wr_addr)) begin
        data_s = i_wr_data;
      end else begin
        data_s = view_s[addr_s];
      end
`endif
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: directed test-plan cycles followed by random traffic against an array model.
module tb_register_file;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int NP = 2;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_wr_enable = 1'b0;
  logic [AW-1:0]     i_wr_addr = '0;
  logic [DW-1:0]     i_wr_data = '0;
  logic [NP*AW-1:0]  i_rd_addr = '0;
  logic [NP*DW-1:0]  o_rd_data;

  register_file #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD_PORTS(NP)) dut (
    .clk(clk), .rst(rst), .i_wr_enable(i_wr_enable), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            port;
    logic [DW-1:0] exp;
    logic [8*16-1:0] tag;
  } chk_t;

  chk_t          sb[$];
  logic [DW-1:0] mem [NR];
  bit            model_valid = 1'b0;
  int            n_checks = 0;
  int            n_fail = 0;

  // Reference model: architectural contents after each edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) mem[i] <= '0;
      model_valid <= 1'b1;
    end else if (i_wr_enable && i_wr_addr != 5'd0) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (a == 5'd0) return 32'h0;
    if (BYPASS && i_wr_enable && !rst && a == i_wr_addr) return i_wr_data;
    return mem[a];
  endfunction

  // Monitor: read data is valid mid-cycle; compare everything queued for this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      chk_t e;
      logic [DW-1:0] act;
      e = sb.pop_front();
      act = o_rd_data[e.port*DW +: DW];
      n_checks++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %0s port%0d got %h expected %h", e.tag, e.port, act, e.exp);
      end
    end
  end

  task automatic expect_const(input int port, input logic [DW-1:0] v, input logic [8*16-1:0] tag);
    chk_t e;
    e.port = port; e.exp = v; e.tag = tag;
    sb.push_back(e);
  endtask

  // One cycle: wait for the edge, drive new inputs, queue model expectations for both ports.
  task automatic step(input logic r, input logic we, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    @(posedge clk);
    #1;
    rst = r; i_wr_enable = we; i_wr_addr = wa; i_wr_data = wd;
    i_rd_addr = {ra1, ra0};
    if (model_valid) begin
      expect_const(0, model_read(ra0), "model");
      expect_const(1, model_read(ra1), "model");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    // reset clear
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    step(1'b1, 1'b1, 5'd5, 32'h00000011, 5'd5, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    expect_const(0, 32'h00000000, "reset_clear");
    // basic write/read
    step(1'b0, 1'b1, 5'd1, 32'hA5A5A5A5, 5'd1, 5'd31);
    step(1'b0, 1'b1, 5'd31, 32'h3C3C3C3C, 5'd1, 5'd31);
    expect_const(0, 32'hA5A5A5A5, "basic_r1");
    step(1'b0, 1'b0, 5'd1, 32'hFFFFFFFF, 5'd1, 5'd31);
    expect_const(0, 32'hA5A5A5A5, "en_low_r1");
    expect_const(1, 32'h3C3C3C3C, "basic_r31");
    step(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd1);
    expect_const(0, 32'h00000000, "r0_during_wr");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd1);
    expect_const(0, 32'h00000000, "r0_after_wr");
    expect_const(1, 32'hA5A5A5A5, "en_low_keep");
    // same-address dual read
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd1);
    expect_const(0, 32'hA5A5A5A5, "dual_p0");
    expect_const(1, 32'hA5A5A5A5, "dual_p1");
    // write/read collision
    step(1'b0, 1'b1, 5'd7, 32'h00000055, 5'd0, 5'd0);
    step(1'b0, 1'b1, 5'd7, 32'h000000AA, 5'd7, 5'd0);
    expect_const(0, BYPASS ? 32'h000000AA : 32'h00000055, "collide_pre");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0);
    expect_const(0, 32'h000000AA, "collide_post");
    // back-to-back writes; mid-sequence reads see the next write when forwarding is on
    step(1'b0, 1'b1, 5'd2, 32'd1, 5'd0, 5'd0);
    step(1'b0, 1'b1, 5'd2, 32'd2, 5'd2, 5'd0);
    expect_const(0, BYPASS ? 32'd2 : 32'd1, "b2b_1");
    step(1'b0, 1'b1, 5'd2, 32'd3, 5'd2, 5'd0);
    expect_const(0, BYPASS ? 32'd3 : 32'd2, "b2b_2");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd2);
    expect_const(0, 32'd3, "b2b_3");
    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] wa, ra0, ra1;
      wa  = AW'($urandom_range(0, NR-1));
      ra0 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NR-1));
      ra1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NR-1));
      step(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), wa, $urandom, ra0, ra1);
    end
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left %0d expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
